// File: rtl/half_subtractor_pkg.sv
// Shared lane arithmetic for the half subtractor: reset level and the a - b lane function.
package half_subtractor_pkg;

  localparam logic HS_RESET_VAL = 1'b0;

  typedef struct packed {
    logic borrow;
    logic difference;
  } hs_res_t;

  // Single-lane a - b; borrow is set only when a=0 and b=1.
  function automatic hs_res_t hs_lane(input logic a, input logic b);
    hs_res_t r;
    r.difference = a ^ b;
    r.borrow     = ~a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_subtractor_if.sv
// Operand/result bundle for the lane-parallel half subtractor, with valid qualifiers on both sides.
interface half_subtractor_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] difference;
  logic [WIDTH-1:0] borrow;
  logic             out_valid;

  modport master (
    output a, b, in_valid,
    input  difference, borrow, out_valid
  );

  modport slave (
    input  a, b, in_valid,
    output difference, borrow, out_valid
  );

endinterface

// File: rtl/half_subtractor_cell.sv
// Combinational 1-bit half subtractor: zero latency, no flow control.
module half_subtractor_cell
  import half_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic difference,
  output logic borrow
);

  hs_res_t res;

  assign res        = hs_lane(a, b);
  assign difference = res.difference;
  assign borrow     = res.borrow;

endmodule

// File: rtl/half_subtractor.sv
// Lane-parallel half subtractor; 1-cycle registered (REG_OUT=1) or combinational (REG_OUT=0).
// Accepts one operand pair per cycle, never stalls; idle cycles hold the last result with out_valid=0.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  half_subtractor_if.slave  bus
);

  if (WIDTH < 1) begin : g_width_chk
    $error("half_subtractor: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] borrow_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_cell u_cell (
      .a          (bus.a[i]),
      .b          (bus.b[i]),
      .difference (diff_c[i]),
      .borrow     (borrow_c[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] borrow_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        diff_q   <= {WIDTH{HS_RESET_VAL}};
        borrow_q <= {WIDTH{HS_RESET_VAL}};
        vld_q    <= 1'b0;
      end else begin
        vld_q <= bus.in_valid;
        // Idle cycles keep the last result so downstream can still observe it.
        if (bus.in_valid) begin
          diff_q   <= diff_c;
          borrow_q <= borrow_c;
        end
      end
    end

    assign bus.difference = diff_q;
    assign bus.borrow     = borrow_q;
    assign bus.out_valid  = vld_q;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign bus.difference = diff_c;
    assign bus.borrow     = borrow_c;
    assign bus.out_valid  = bus.in_valid;
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench: registered WIDTH=1 and WIDTH=4 instances plus a combinational WIDTH=1 instance.
module tb_half_subtractor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  half_subtractor_if #(.WIDTH(1)) bus1 ();
  half_subtractor_if #(.WIDTH(4)) bus4 ();
  half_subtractor_if #(.WIDTH(1)) busc ();

  half_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_subtractor #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  half_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .bus(busc));

  typedef struct {
    logic [3:0] diff;
    logic [3:0] borrow;
    logic       vld;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  // Last captured results, held across idle cycles.
  logic [3:0] m1_d = '0, m1_b = '0, m4_d = '0, m4_b = '0;

  // Truth table indexed by {a,b}: 00,01,10,11.
  logic [3:0] diff_tab   = 4'b0110;
  logic [3:0] borrow_tab = 4'b0010;

  int errors = 0;
  int checks = 0;
  int seq    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_diff(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = diff_tab[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [3:0] ref_borrow(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = borrow_tab[{a[i], b[i]}];
    return r;
  endfunction

  task automatic apply(input logic a1, input logic b1, input logic v1,
                       input logic [3:0] a4, input logic [3:0] b4, input logic v4);
    exp_t e;
    bus1.a = a1; bus1.b = b1; bus1.in_valid = v1;
    bus4.a = a4; bus4.b = b4; bus4.in_valid = v4;
    if (v1) begin
      m1_d = ref_diff({3'b000, a1}, {3'b000, b1});
      m1_b = ref_borrow({3'b000, a1}, {3'b000, b1});
    end
    if (v4) begin
      m4_d = ref_diff(a4, b4);
      m4_b = ref_borrow(a4, b4);
    end
    e.diff = m1_d; e.borrow = m1_b; e.vld = v1;
    q1.push_back(e);
    e.diff = m4_d; e.borrow = m4_b; e.vld = v4;
    q4.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check($sformatf("d1_vld#%0d", seq),    {7'b0, bus1.out_valid},  {7'b0, e.vld});
      check($sformatf("d1_diff#%0d", seq),   {7'b0, bus1.difference}, {7'b0, e.diff[0]});
      check($sformatf("d1_borrow#%0d", seq), {7'b0, bus1.borrow},     {7'b0, e.borrow[0]});
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check($sformatf("d4_vld#%0d", seq),    {7'b0, bus4.out_valid},  {7'b0, e.vld});
      check($sformatf("d4_diff#%0d", seq),   {4'b0, bus4.difference}, {4'b0, e.diff});
      check($sformatf("d4_borrow#%0d", seq), {4'b0, bus4.borrow},     {4'b0, e.borrow});
    end
    seq++;
  endtask

  task automatic cycle_drive(input logic a1, input logic b1, input logic v1,
                             input logic [3:0] a4, input logic [3:0] b4, input logic v4);
    @(negedge clk);
    pop_check();
    apply(a1, b1, v1, a4, b4, v4);
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_d1_vld"},    {7'b0, bus1.out_valid},  8'h00);
    check({tag, "_d1_diff"},   {7'b0, bus1.difference}, 8'h00);
    check({tag, "_d1_borrow"}, {7'b0, bus1.borrow},     8'h00);
    check({tag, "_d4_vld"},    {7'b0, bus4.out_valid},  8'h00);
    check({tag, "_d4_diff"},   {4'b0, bus4.difference}, 8'h00);
    check({tag, "_d4_borrow"}, {4'b0, bus4.borrow},     8'h00);
  endtask

  task automatic comb_check(input logic a, input logic b, input logic v);
    logic [3:0] d, br;
    busc.a = a; busc.b = b; busc.in_valid = v;
    #1;
    d  = ref_diff({3'b000, a}, {3'b000, b});
    br = ref_borrow({3'b000, a}, {3'b000, b});
    check("comb_diff",   {7'b0, busc.difference}, {7'b0, d[0]});
    check("comb_borrow", {7'b0, busc.borrow},     {7'b0, br[0]});
    check("comb_vld",    {7'b0, busc.out_valid},  {7'b0, v});
  endtask

  initial begin
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.in_valid = 1'b1;
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.in_valid = 1'b1;
    busc.a = 1'b0; busc.b = 1'b0; busc.in_valid = 1'b0;

    // Held in reset across edges with valid operands present.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_check("reset");
    end
    comb_check(1'b0, 1'b1, 1'b1);
    comb_check(1'b1, 1'b1, 1'b0);

    rst_n = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b1);

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      cycle_drive(ab[1], ab[0], 1'b1, 4'(i * 7 + 3), 4'(i * 9 + 6), 1'b1);
      comb_check(ab[1], ab[0], 1'b1);
    end

    // Hold: valid 0/1, then two idle cycles with different operands.
    cycle_drive(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0101, 1'b1);
    cycle_drive(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0);
    cycle_drive(1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
    cycle_drive(1'b1, 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b1);

    // Asynchronous reset asserted between edges.
    @(posedge clk);
    #2;
    pop_check();
    rst_n = 1'b0;
    #1;
    rst_check("async_rst");
    m1_d = '0; m1_b = '0; m4_d = '0; m4_b = '0;
    @(posedge clk);
    #1;
    rst_check("rst_held");

    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b1, 1'b1, 4'b0101, 4'b0110, 1'b1);
    cycle_drive(1'b1, 1'b1, 1'b1, 4'b1001, 4'b1111, 1'b1);
    cycle_drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
